// File: rtl/led_ctrl_pkg.sv
// Shared encodings and seed helpers for the LED running-light sequencer.
// Seed helpers return a wide vector; callers truncate to their LED width.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_LEFT     = 2'd0,
    MODE_RIGHT    = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_BAR      = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int unsigned SEED_MAX_W = 64;

  function automatic logic [SEED_MAX_W-1:0] seed_lsb();
    return SEED_MAX_W'(1);
  endfunction

  function automatic logic [SEED_MAX_W-1:0] seed_msb(input int unsigned led_w);
    return SEED_MAX_W'(1) << (led_w - 1);
  endfunction

  function automatic logic [SEED_MAX_W-1:0] mode_seed(input mode_e m, input int unsigned led_w);
    return (m == MODE_RIGHT) ? seed_msb(led_w) : seed_lsb();
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button to single-cycle press event: 2-FF synchronizer, stability
// counter and a registered rising-edge detector on the debounced level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_pulse;

  // r_cnt counts consecutive synchronized samples that disagree with r_level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign pulse = r_pulse;

endmodule

// File: rtl/led_pattern_controller.sv
// Running-light sequencer: debounced buttons drive an IDLE/RUN/PAUSE FSM,
// a speed-scaled prescaler and one of four LED patterns.
module led_pattern_controller
  import led_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES     = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 2000000,
  parameter int unsigned LED_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_mode,
  input  logic             btn_speed,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             running
);

  localparam int unsigned      PW       = $clog2(STEP_CYCLES + 1);
  localparam logic [PW-1:0]    STEP_P   = PW'(STEP_CYCLES);
  localparam logic [LED_W-1:0] SEED_L   = LED_W'(seed_lsb());
  localparam logic [LED_W-1:0] SEED_M   = LED_W'(seed_msb(LED_W));
  localparam logic [LED_W-1:0] ALL_ONES = '1;

  logic             w_start_ev;
  logic             w_mode_ev;
  logic             w_speed_ev;
  logic [PW-1:0]    w_period;
  logic             w_step;
  logic [LED_W-1:0] w_next_led;
  dir_e             w_next_dir;
  mode_e            w_mode_inc;

  state_e           r_state;
  mode_e            r_mode;
  logic [1:0]       r_speed;
  dir_e             r_dir;
  logic [PW-1:0]    r_presc;
  logic [LED_W-1:0] r_led;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .btn_raw(btn_start), .pulse(w_start_ev)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .btn_raw(btn_mode), .pulse(w_mode_ev)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk(clk), .rst(rst), .btn_raw(btn_speed), .pulse(w_speed_ev)
  );

  assign w_period   = STEP_P >> r_speed;
  assign w_step     = (r_presc >= (w_period - PW'(1)));
  assign w_mode_inc = mode_e'(r_mode + 2'd1);

  always_comb begin
    w_next_led = r_led;
    w_next_dir = r_dir;
    case (r_mode)
      MODE_LEFT:  w_next_led = (r_led == SEED_M) ? SEED_L : (r_led << 1);
      MODE_RIGHT: w_next_led = (r_led == SEED_L) ? SEED_M : (r_led >> 1);
      MODE_PINGPONG: begin
        // Direction flips on the step that lands on an end LED, so ends light once.
        if (r_dir == DIR_LEFT) begin
          w_next_led = r_led << 1;
          if (w_next_led[LED_W-1]) w_next_dir = DIR_RIGHT;
        end else begin
          w_next_led = r_led >> 1;
          if (w_next_led[0]) w_next_dir = DIR_LEFT;
        end
      end
      MODE_BAR:   w_next_led = (r_led == ALL_ONES) ? SEED_L : ((r_led << 1) | SEED_L);
      default:    w_next_led = r_led;
    endcase
  end

  // Event priority start > mode > speed; a step only happens on an event-free edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_LEFT;
      r_speed <= 2'd0;
      r_dir   <= DIR_LEFT;
      r_presc <= '0;
      r_led   <= '0;
    end else if (w_start_ev) begin
      case (r_state)
        ST_IDLE: begin
          r_led   <= LED_W'(mode_seed(r_mode, LED_W));
          r_presc <= '0;
          r_dir   <= DIR_LEFT;
          r_state <= ST_RUN;
        end
        ST_RUN:   r_state <= ST_PAUSE;
        ST_PAUSE: r_state <= ST_RUN;
        default:  r_state <= ST_IDLE;
      endcase
    end else if (w_mode_ev) begin
      r_mode <= w_mode_inc;
      if (r_state != ST_IDLE) begin
        r_led   <= LED_W'(mode_seed(w_mode_inc, LED_W));
        r_presc <= '0;
        r_dir   <= DIR_LEFT;
      end
    end else if (w_speed_ev) begin
      r_speed <= r_speed + 2'd1;
      r_presc <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_step) begin
        r_led   <= w_next_led;
        r_dir   <= w_next_dir;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign led     = r_led;
  assign mode    = r_mode;
  assign speed   = r_speed;
  assign running = (r_state == ST_RUN);

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller with short step/debounce periods.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_led_pattern_controller;

  localparam int unsigned STEP_CYCLES     = 16;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned LED_W           = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_start;
  logic             btn_mode;
  logic             btn_speed;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic             running;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pp_exp [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  led_pattern_controller #(
    .STEP_CYCLES(STEP_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LED_W(LED_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start(btn_start),
    .btn_mode(btn_mode),
    .btn_speed(btn_speed),
    .led(led),
    .mode(mode),
    .speed(speed),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] e;
    rst       = 1'b0;
    btn_start = 1'b0;
    btn_mode  = 1'b0;
    btn_speed = 1'b0;
    repeat (3) tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_speed", 32'(speed), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    rst = 1'b1;
    tick();

    // Start press: pulse after 7 edges, seed visible after the 8th.
    btn_start = 1'b1;
    repeat (6) tick();
    check("pre_evt_led", 32'(led), 32'h0);
    tick();
    check("evt_edge_running", 32'(running), 32'h0);
    tick();
    check("seed_led", 32'(led), 32'h01);
    check("seed_running", 32'(running), 32'h1);
    repeat (2) tick();
    btn_start = 1'b0;
    repeat (13) tick();
    check("left_hold15", 32'(led), 32'h01);
    tick();
    check("left_step1", 32'(led), 32'h02);
    for (int i = 2; i <= 8; i++) begin
      repeat (16) tick();
      e = 8'h01 << (i % 8);
      check("left_step", 32'(led), 32'(e));
    end

    // Short mode glitch is rejected.
    btn_mode = 1'b1;
    repeat (3) tick();
    btn_mode = 1'b0;
    repeat (9) tick();
    check("glitch_mode", 32'(mode), 32'h0);
    repeat (4) tick();
    check("left_step9", 32'(led), 32'h02);

    btn_mode = 1'b1;
    repeat (8) tick();
    check("mode1_mode", 32'(mode), 32'h1);
    check("mode1_seed", 32'(led), 32'h80);
    btn_mode = 1'b0;
    repeat (15) tick();
    check("mode1_hold", 32'(led), 32'h80);
    tick();
    check("mode1_step", 32'(led), 32'h40);

    btn_mode = 1'b1;
    repeat (8) tick();
    check("mode2_mode", 32'(mode), 32'h2);
    check("mode2_seed", 32'(led), 32'h01);
    btn_mode = 1'b0;
    for (int i = 0; i < 14; i++) begin
      repeat (16) tick();
      check("pingpong", 32'(led), 32'(pp_exp[i]));
    end
    repeat (16) tick();
    check("pingpong_wrap", 32'(led), 32'h02);

    // Three speed presses: P = 16 >> 3 = 2.
    for (int k = 0; k < 3; k++) begin
      btn_speed = 1'b1;
      repeat (8) tick();
      btn_speed = 1'b0;
      repeat (8) tick();
    end
    check("speed3", 32'(speed), 32'h3);

    btn_mode = 1'b1;
    repeat (8) tick();
    check("mode3_mode", 32'(mode), 32'h3);
    check("mode3_seed", 32'(led), 32'h01);
    btn_mode = 1'b0;
    tick();
    check("bar_hold", 32'(led), 32'h01);
    tick();
    check("bar_step1", 32'(led), 32'h03);
    for (int i = 2; i <= 8; i++) begin
      repeat (2) tick();
      e = (i == 8) ? 8'h01 : 8'((16'h1 << (i + 1)) - 16'h1);
      check("bar_step", 32'(led), 32'(e));
    end

    // Speed wraps to 0 (P = 16); bar keeps stepping every 2 until the event.
    btn_speed = 1'b1;
    repeat (8) tick();
    check("speed_wrap", 32'(speed), 32'h0);
    check("speed_wrap_led", 32'(led), 32'h0F);
    btn_speed = 1'b0;
    repeat (15) tick();
    check("slow_hold", 32'(led), 32'h0F);
    tick();
    check("slow_step", 32'(led), 32'h1F);

    // Pause 7 counts into the period, hold 100 cycles, resume.
    btn_start = 1'b1;
    repeat (8) tick();
    check("pause_running", 32'(running), 32'h0);
    check("pause_led", 32'(led), 32'h1F);
    btn_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("paused_led", 32'(led), 32'h1F);
      check("paused_running", 32'(running), 32'h0);
    end
    btn_start = 1'b1;
    repeat (8) tick();
    check("resume_running", 32'(running), 32'h1);
    check("resume_led", 32'(led), 32'h1F);
    btn_start = 1'b0;
    repeat (8) tick();
    check("resume_hold", 32'(led), 32'h1F);
    tick();
    check("resume_step", 32'(led), 32'h3F);

    // Simultaneous start and mode: only start acts.
    btn_start = 1'b1;
    btn_mode  = 1'b1;
    repeat (8) tick();
    check("simul_running", 32'(running), 32'h0);
    check("simul_mode", 32'(mode), 32'h3);
    check("simul_led", 32'(led), 32'h3F);
    btn_start = 1'b0;
    btn_mode  = 1'b0;
    repeat (10) tick();

    btn_start = 1'b1;
    repeat (8) tick();
    check("rerun_running", 32'(running), 32'h1);
    btn_start = 1'b0;
    btn_speed = 1'b1;
    repeat (8) tick();
    check("rerun_speed", 32'(speed), 32'h1);
    btn_speed = 1'b0;
    repeat (4) tick();

    // One-cycle reset in RUN.
    rst = 1'b0;
    tick();
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_mode", 32'(mode), 32'h0);
    check("midrst_speed", 32'(speed), 32'h0);
    check("midrst_running", 32'(running), 32'h0);
    rst = 1'b1;
    repeat (20) tick();
    check("idle_led", 32'(led), 32'h0);
    check("idle_running", 32'(running), 32'h0);
    btn_start = 1'b1;
    repeat (8) tick();
    check("restart_led", 32'(led), 32'h01);
    check("restart_running", 32'(running), 32'h1);
    btn_start = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_controller.md
Name: led_pattern_controller

Overview:
- Sequencer for the board's 8-LED running-light datapath.
- Turns three raw push-buttons (start/pause, mode, speed) into debounced single-cycle events and runs a RUN/PAUSE state machine.
- Generates the step tick from a programmable prescaler and drives `led` with one of four patterns.
- Sits directly between the board buttons and the LED pins.

Parameters:
- STEP_CYCLES, 100000000: clk cycles per pattern step at speed 0 (1 s at 100 MHz).
- DEBOUNCE_CYCLES, 2000000: consecutive stable samples required to accept a button level (20 ms).
- LED_W, 8: LED count; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-low.
- btn_start  input  1  raw start/pause button, active-high, asynchronous to clk.
- btn_mode  input  1  raw mode-cycle button, active-high, asynchronous.
- btn_speed  input  1  raw speed-cycle button, active-high, asynchronous.
- led  output  LED_W  LED drive, 1 = lit.
- mode  output  2  current pattern: 0 left, 1 right, 2 ping-pong, 3 bar.
- speed  output  2  current speed index.
- running  output  1  high only in RUN.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: led=0, mode=0, speed=0, running=0.
  - Internal: state=IDLE, prescaler=0, ping-pong dir=left, debouncers cleared.
  - Reset mid-operation aborts everything at that edge; button events in the same cycle are dropped.
- Button path, per button:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - A one-cycle event pulse fires on the debounced 0->1 edge; releases generate nothing.
  - Event latency from a stable raw rise is DEBOUNCE_CYCLES+3 clk cycles, exactly.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: led=0. A start event loads the seed for the current mode, clears the prescaler and goes to RUN.
  - RUN: prescaler counts 0..P-1, where P = STEP_CYCLES >> speed. At count P-1 a step occurs and the prescaler returns to 0. A start event goes to PAUSE.
  - PAUSE: led and prescaler hold. A start event returns to RUN and resumes counting from the held prescaler value.
- Mode event:
  - mode <= mode+1 (wraps 3->0).
  - In RUN or PAUSE: led reloads the new seed, prescaler=0, dir=left, state unchanged.
  - In IDLE: only mode changes.
- Speed event:
  - speed <= speed+1 (wraps 3->0) in any state.
  - Prescaler=0; pattern untouched.
- Simultaneous events: priority start > mode > speed; lower-priority events in the same cycle are discarded.
- Pattern step rules; all shifts are LED_W wide with no overflow bits:
  - mode 0: seed 0...01. Step = shift left by 1; MSB-only wraps to 0...01.
  - mode 1: seed 10...0. Step = shift right by 1; LSB-only wraps to 10...0.
  - mode 2: seed 0...01, dir=left. Step moves one position in dir. Reaching MSB sets dir=right; reaching LSB sets dir=left. End LEDs are lit for one step only, so the period is 2*(LED_W-1) steps.
  - mode 3: seed 0...01. Step = (led<<1)|1; all-ones steps back to 0...01.
- Timing:
  - led updates on the clk edge where the step condition is true.
  - First step after entering RUN from IDLE occurs P cycles after the cycle the led seed appears.
  - Outputs are registered, with no combinational path from inputs.
- running = (state==RUN).

Decomposition:
- Shared package led_ctrl_pkg holds:
  - state encoding (IDLE/RUN/PAUSE);
  - mode encoding (MODE_LEFT, MODE_RIGHT, MODE_PINGPONG, MODE_BAR);
  - seed functions of LED_W.
- One sub-module, button_debounce (params DEBOUNCE_CYCLES; ports clk, rst, btn_raw, pulse), instantiated three times.
- FSM, prescaler and pattern logic stay in the top.

Test Plan (STEP_CYCLES=16, DEBOUNCE_CYCLES=4, LED_W=8):
- Reset then start press held 10 cycles -> one event 7 cycles after the rise. led=00000001, running=1; led=00000010 exactly 16 cycles later; after 8 steps led=00000001 again.
- Raw btn_mode pulses of 3 cycles -> no event and mode stays 0. A held press in RUN -> mode=1, led=10000000, prescaler restarts; next step gives 01000000.
- Mode 2 from seed -> sequence 01,02,04,…,80,40,…,01 (hex): 14 steps per period, 0x80 and 0x01 each seen once per period.
- Speed pressed three times -> steps every 2 cycles; mode 3 from seed gives 01,03,07,…,FF,01.
- Start during RUN -> PAUSE: led and prescaler frozen for 100 cycles. Start again -> the next step lands exactly when the remaining prescaler count expires.
- Start and mode events in the same cycle -> only the start effect occurs, mode unchanged. rst low mid-RUN for 1 cycle -> all outputs 0, state IDLE the next cycle.
